if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC register, next-PC selection, the request/ready handshake to instruction memory and the IF/ID pipeline register. It sits directly upstream of the ID-stage hazard logic. It consumes that logic's `DataHazard` (hold) and `JumpHazard` (flush) together with the ID-stage `PCSrc` and redirect targets. It produces the valid/instruction/PC+4 triple that ID decodes.

## Interface
- `RESET_PC`, 32'h8000_0000: PC after reset.
- `INTR_VECTOR`, 32'h8000_0004: interrupt handler address.
- `EXC_VECTOR`, 32'h8000_0008: exception handler address.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `PCSrc` in 3: next-PC select from ID:
  - 000 sequential.
  - 001 jump target.
  - 010 jump-register target.
  - 011 taken branch.
- `jump_target`, `jr_target`, `branch_target` in 32 each: redirect addresses.
- `ExceptionOrInterrupt` in 1: trap request.
- `IsInterrupt` in 1: selects `INTR_VECTOR` when set, otherwise `EXC_VECTOR`.
- `DataHazard` in 1: hold PC and IF/ID.
- `JumpHazard` in 1: invalidate the IF/ID contents loaded this edge.
- `imem_req` out 1, `imem_addr` out 32: fetch request.
- `imem_ready` in 1, `imem_rdata` in 32: fetch completion; data is valid in the same cycle as `imem_ready`.
- `if_id_valid` out 1, `if_id_instr` out 32, `if_id_pc_plus4` out 32: IF/ID register.
- `pc` out 32: current fetch PC.
- `bubble_count` out 32: see Configuration.

## Operation
- Redirect condition:
  - `ExceptionOrInterrupt` asserted: target is the selected vector; this has priority over everything else.
  - Otherwise, `PCSrc != 000` and `DataHazard == 0`: target is the `PCSrc`-selected input.
  - `PCSrc` 1xx is illegal; treat it as 000.
- FSM has three states.
- FETCH:
  - `imem_req = 1`, `imem_addr = pc`.
  - On `imem_ready` with a redirect: drop the data, load `pc <=` target, stay in FETCH.
  - On `imem_ready` with `DataHazard` (and no trap): store `imem_rdata` in the skid buffer and go to HOLD.
  - On `imem_ready` otherwise: load IF/ID with {1, `imem_rdata`, pc+4} and set `pc <= pc+4`.
  - Redirect without `imem_ready`: latch the target into `redirect_pc` and go to DISCARD.
- HOLD:
  - `imem_req = 0`.
  - When `DataHazard` falls: load IF/ID from the skid buffer, set `pc <= pc+4`, go to FETCH.
  - On a redirect: drop the buffer, set `pc <=` target, go to FETCH.
- DISCARD:
  - `imem_req = 1` with the old `pc` (address is held stable).
  - On `imem_ready`: drop the data, set `pc <= redirect_pc`, go to FETCH.
  - A trap arriving in DISCARD overwrites `redirect_pc` with the vector.
- IF/ID update rules, highest priority first:
  1. `ExceptionOrInterrupt` forces `if_id_valid <= 0`.
  2. Else `DataHazard` holds all three IF/ID fields.
  3. Else `JumpHazard` forces `if_id_valid <= 0`.
  4. Else, if no instruction was delivered this cycle, a bubble is inserted (`if_id_valid <= 0`; instr and pc_plus4 hold).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Request rule: while `imem_req && !imem_ready`, `imem_addr` must not change.

## Timing
- Reset values:
  - `pc = RESET_PC`, state FETCH.
  - `imem_req = 0` while `reset` is low, 1 in the first cycle after release.
  - `if_id_valid = 0`, `if_id_instr = 0`, `if_id_pc_plus4 = 0`.
  - Skid buffer 0, `redirect_pc = 0`, `bubble_count = 0`.
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle; IF/ID is valid one edge after the fetch cycle.
- Redirect with zero-wait memory: the target is fetched the cycle after redirect; one bubble enters ID.
- Redirect during an outstanding request: the target is fetched the cycle after the old request's `imem_ready`.
- Reset asserted mid-request: the request is abandoned immediately; memory must tolerate `imem_req` dropping without `imem_ready`.

## Configuration
- `IF_BUBBLE_CNT_EN` defined: `bubble_count` increments (wrapping) on every edge where `if_id_valid` is loaded with 0, including flushes and the bubbles of rule 4.
- Not defined: no counter register; `bubble_count` is tied to 0.

## Structure
- Shared header `cpu_defines.vh` holds:
  - `PCSrc` encodings.
  - FSM state encodings.
  - Default vector constants.
- One sub-module, `if_id_reg`: the valid/instr/pc_plus4 register with hold, flush and bubble inputs.
- The FSM, PC and next-PC mux stay in the top module.

## Test plan
- Reset release, `imem_ready=1`, rdata 0x2408_0001 → first request addr 0x8000_0000; next edge `if_id_valid=1`, `if_id_pc_plus4=0x8000_0004`.
- `PCSrc=001`, `jump_target=0x8000_0100`, `JumpHazard=1` → IF/ID invalid; next `imem_addr=0x8000_0100`.
- `DataHazard=1` for 2 cycles with a fetch completing → IF/ID held, FSM in HOLD with `imem_req=0`; after release the buffered instruction enters IF/ID with no refetch.
- `imem_ready` delayed 3 cycles; `PCSrc=010`, `jr_target=0x8000_0200` in cycle 1 → `imem_addr` stable 3 cycles, returned data dropped, then fetch from 0x8000_0200.
- `ExceptionOrInterrupt=1`, `IsInterrupt=1` together with `DataHazard=1` → IF/ID flushed, `pc=0x8000_0004`.
- With `IF_BUBBLE_CNT_EN` defined, scenarios 2 and 4 run back-to-back from reset → `bubble_count` equals the number of invalid IF/ID loads (nonzero); without the macro it stays 0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: next-PC select
// encodings, fetch FSM states, default vectors and the PC increment helper.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [2:0] PCSRC_SEQ    = 3'b000;
    localparam logic [2:0] PCSRC_JUMP   = 3'b001;
    localparam logic [2:0] PCSRC_JR     = 3'b010;
    localparam logic [2:0] PCSRC_BRANCH = 3'b011;

    localparam logic [31:0] DEF_RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] DEF_INTR_VECTOR = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VECTOR  = 32'h8000_0008;

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] cur_pc);
        return cur_pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc_plus4 with flush, hold and bubble
// controls (flush beats hold, hold beats bubble/load).
module if_fetch_stage_if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        hold,
    input  logic        bubble,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    // IF/ID state update; a flush or bubble only clears valid, payload holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= 1'b0;
            instr    <= 32'd0;
            pc_plus4 <= 32'd0;
        end else if (flush) begin
            valid    <= 1'b0;
        end else if (hold) begin
            valid    <= valid;
        end else if (bubble) begin
            valid    <= 1'b0;
        end else begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc_plus4 <= load_pc_plus4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, imem handshake FSM and IF/ID.
// Optional feature macro: IF_BUBBLE_CNT_EN (counts invalid IF/ID loads).
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] INTR_VECTOR = DEF_INTR_VECTOR,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  PCSrc,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] branch_target,
    input  logic        ExceptionOrInterrupt,
    input  logic        IsInterrupt,
    input  logic        DataHazard,
    input  logic        JumpHazard,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] pc,
    output logic [31:0] bubble_count
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  redirect_pc_r;
    logic [31:0]  skid_r;

    logic         redirect_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_plus4_s;
    logic         deliver_s;
    logic [31:0]  deliver_instr_s;
    logic         flush_s;
    logic         hold_s;

    assign pc_plus4_s = next_seq_pc(pc_r);

    // Redirect detection and target mux; traps override, a data hazard masks PCSrc.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = pc_plus4_s;
        if (ExceptionOrInterrupt) begin
            redirect_s = 1'b1;
            target_s   = IsInterrupt ? INTR_VECTOR : EXC_VECTOR;
        end else if (!DataHazard) begin
            case (PCSrc)
                PCSRC_JUMP: begin
                    redirect_s = 1'b1;
                    target_s   = jump_target;
                end
                PCSRC_JR: begin
                    redirect_s = 1'b1;
                    target_s   = jr_target;
                end
                PCSRC_BRANCH: begin
                    redirect_s = 1'b1;
                    target_s   = branch_target;
                end
                default: begin
                    redirect_s = 1'b0;
                    target_s   = pc_plus4_s;
                end
            endcase
        end else begin
            redirect_s = 1'b0;
            target_s   = pc_plus4_s;
        end
    end

    // Decide whether an instruction reaches IF/ID this cycle and from where.
    always_comb begin
        deliver_s       = 1'b0;
        deliver_instr_s = imem_rdata;
        case (state_r)
            ST_FETCH: begin
                if (imem_ready && !redirect_s && !DataHazard) begin
                    deliver_s = 1'b1;
                end else begin
                    deliver_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!redirect_s && !DataHazard) begin
                    deliver_s       = 1'b1;
                    deliver_instr_s = skid_r;
                end else begin
                    deliver_s = 1'b0;
                end
            end
            default: begin
                deliver_s = 1'b0;
            end
        endcase
    end

    // Fetch FSM with PC, skid buffer and pending-redirect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            redirect_pc_r <= 32'd0;
            skid_r        <= 32'd0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (redirect_s) begin
                            pc_r <= target_s;
                        end else if (DataHazard) begin
                            skid_r  <= imem_rdata;
                            state_r <= ST_HOLD;
                        end else begin
                            pc_r <= pc_plus4_s;
                        end
                    end else if (redirect_s) begin
                        redirect_pc_r <= target_s;
                        state_r       <= ST_DISCARD;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (redirect_s) begin
                        pc_r    <= target_s;
                        state_r <= ST_FETCH;
                    end else if (!DataHazard) begin
                        pc_r    <= pc_plus4_s;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DISCARD: begin
                    // Address stays on the old pc until memory completes the stale request.
                    if (imem_ready) begin
                        pc_r    <= ExceptionOrInterrupt ? target_s : redirect_pc_r;
                        state_r <= ST_FETCH;
                    end else if (ExceptionOrInterrupt) begin
                        redirect_pc_r <= target_s;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // The request is gated directly by reset so it drops the moment reset asserts.
    assign imem_req  = reset && (state_r != ST_HOLD);
    assign imem_addr = pc_r;
    assign pc        = pc_r;

    assign flush_s = ExceptionOrInterrupt || (!DataHazard && JumpHazard);
    assign hold_s  = DataHazard && !ExceptionOrInterrupt;

    if_fetch_stage_if_id_reg u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush_s),
        .hold          (hold_s),
        .bubble        (!deliver_s),
        .load_instr    (deliver_instr_s),
        .load_pc_plus4 (pc_plus4_s),
        .valid         (if_id_valid),
        .instr         (if_id_instr),
        .pc_plus4      (if_id_pc_plus4)
    );

`ifdef IF_BUBBLE_CNT_EN
    logic [31:0] bubble_count_r;
    logic        zero_load_s;

    assign zero_load_s = flush_s || (!hold_s && !deliver_s);

    // Count every edge on which IF/ID valid is loaded with 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count_r <= 32'd0;
        end else if (zero_load_s) begin
            bubble_count_r <= bubble_count_r + 32'd1;
        end else begin
            bubble_count_r <= bubble_count_r;
        end
    end

    assign bubble_count = bubble_count_r;
`else
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: directed stimulus pushes expected IF/ID
// payloads, a monitor pops and compares on every fresh valid IF/ID load.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  PCSrc;
    logic [31:0] jump_target, jr_target, branch_target;
    logic        ExceptionOrInterrupt, IsInterrupt, DataHazard, JumpHazard;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic [31:0] pc;
    logic [31:0] bubble_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t exp_q[$];

    if_fetch_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .PCSrc                (PCSrc),
        .jump_target          (jump_target),
        .jr_target            (jr_target),
        .branch_target        (branch_target),
        .ExceptionOrInterrupt (ExceptionOrInterrupt),
        .IsInterrupt          (IsInterrupt),
        .DataHazard           (DataHazard),
        .JumpHazard           (JumpHazard),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ready           (imem_ready),
        .imem_rdata           (imem_rdata),
        .if_id_valid          (if_id_valid),
        .if_id_instr          (if_id_instr),
        .if_id_pc_plus4       (if_id_pc_plus4),
        .pc                   (pc),
        .bubble_count         (bubble_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_q.push_back('{instr: instr, pc4: pc4});
    endtask

    task automatic set_in(input logic rdy, input logic [31:0] rdata, input logic [2:0] src,
                          input logic dh, input logic jh, input logic ex, input logic ir);
        imem_ready           = rdy;
        imem_rdata           = rdata;
        PCSrc                = src;
        DataHazard           = dh;
        JumpHazard           = jh;
        ExceptionOrInterrupt = ex;
        IsInterrupt          = ir;
    endtask

    function automatic logic [31:0] bub(input logic [31:0] n);
`ifdef IF_BUBBLE_CNT_EN
        return n;
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: a valid IF/ID after an edge without DataHazard is a fresh load.
    initial begin
        logic held;
        exp_t e;
        forever begin
            @(posedge clk);
            held = DataHazard;
            @(negedge clk);
            if (reset && if_id_valid && !held) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", if_id_instr, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_instr", if_id_instr, e.instr);
                    check("ifid_pc4", if_id_pc_plus4, e.pc4);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        jump_target = 32'd0; jr_target = 32'd0; branch_target = 32'd0;
        set_in(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        check("rst_req", imem_req, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_valid", if_id_valid, 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc4", if_id_pc_plus4, 32'd0);
        check("rst_bub", bubble_count, 32'd0);

        // Scenario 1: first fetch after release
        reset = 1'b1; #1;
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, 32'h8000_0000);
        set_in(1'b1, 32'h2408_0001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h2408_0001, 32'h8000_0004);

        // Scenario 2: jump with flush
        @(negedge clk);
        check("seq_pc", pc, 32'h8000_0004);
        jump_target = 32'h8000_0100;
        set_in(1'b1, 32'h3c01_0000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("jh_valid", if_id_valid, 32'd0);
        check("jump_addr", imem_addr, 32'h8000_0100);
        check("jh_instr_hold", if_id_instr, 32'h2408_0001);
        check("jh_pc4_hold", if_id_pc_plus4, 32'h8000_0004);
        check("bub_jump", bubble_count, bub(32'd1));
        set_in(1'b1, 32'h8c02_0004, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h8c02_0004, 32'h8000_0104);

        // Scenario 3: data hazard for two cycles while a fetch completes
        @(negedge clk);
        check("pre_hold_addr", imem_addr, 32'h8000_0104);
        set_in(1'b1, 32'h0043_1820, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_req", imem_req, 32'd0);
        check("hold_valid", if_id_valid, 32'd1);
        check("hold_instr", if_id_instr, 32'h8c02_0004);
        set_in(1'b0, 32'hffff_ffff, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_req2", imem_req, 32'd0);
        check("hold_instr2", if_id_instr, 32'h8c02_0004);
        set_in(1'b0, 32'hffff_ffff, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h0043_1820, 32'h8000_0108);

        // Scenario 4: jr redirect during a 3-cycle outstanding request
        @(negedge clk);
        check("post_hold_req", imem_req, 32'd1);
        check("post_hold_addr", imem_addr, 32'h8000_0108);
        jr_target = 32'h8000_0200;
        set_in(1'b0, 32'hbad0_0001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("disc_req", imem_req, 32'd1);
        check("disc_addr1", imem_addr, 32'h8000_0108);
        set_in(1'b0, 32'hbad0_0002, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("disc_addr2", imem_addr, 32'h8000_0108);
        set_in(1'b1, 32'hdead_beef, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("jr_addr", imem_addr, 32'h8000_0200);
        check("bub_jr", bubble_count, bub(32'd4));
        set_in(1'b1, 32'h2009_0005, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h2009_0005, 32'h8000_0204);

        // Scenario 5: interrupt together with a data hazard
        @(negedge clk);
        check("pre_trap_pc", pc, 32'h8000_0204);
        set_in(1'b1, 32'h1111_1111, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("trap_valid", if_id_valid, 32'd0);
        check("intr_pc", pc, 32'h8000_0004);
        // Branch pending in DISCARD, then overwritten by an exception
        branch_target = 32'h8000_0300;
        set_in(1'b0, 32'd0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("disc_addr3", imem_addr, 32'h8000_0004);
        set_in(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("disc_addr4", imem_addr, 32'h8000_0004);
        set_in(1'b1, 32'h2222_2222, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("exc_pc", pc, 32'h8000_0008);
        check("bub_trap", bubble_count, bub(32'd8));

        // PC wrap and illegal PCSrc
        jump_target = 32'hffff_fffc;
        set_in(1'b1, 32'h3333_3333, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("top_addr", imem_addr, 32'hffff_fffc);
        set_in(1'b1, 32'h0000_000c, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h0000_000c, 32'h0000_0000);
        @(negedge clk);
        check("wrap_pc", pc, 32'h0000_0000);
        jump_target = 32'h8000_0500;
        set_in(1'b1, 32'h1234_5678, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h1234_5678, 32'h0000_0004);
        @(negedge clk);
        check("illegal_src_pc", pc, 32'h0000_0004);
        set_in(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("bub_final", bubble_count, bub(32'd10));
        check("pending_req", imem_req, 32'd1);

        // Reset in the middle of an outstanding request
        #2 reset = 1'b0;
        #1;
        check("rst_abandon_req", imem_req, 32'd0);
        check("rst2_pc", pc, 32'h8000_0000);
        check("rst2_valid", if_id_valid, 32'd0);
        check("rst2_bub", bubble_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b1, 32'h2408_0002, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h2408_0002, 32'h8000_0004);
        @(negedge clk);
        set_in(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
